// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: word-to-serial loader for a tile configuration chain.
// Define CCFF_CHAIN_LOADER_VERIFY_EN for a second readback/compare pass.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);
    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    localparam logic LAST_PASS = 1'b1;
`else
    localparam logic LAST_PASS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic              pass_q, pass_d;
    logic              head_q, clk_en_q;
    logic              clr;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        pass_d  = pass_q;
        clr     = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        state_d = FETCH;
                        wcnt_d  = '0;
                        bcnt_d  = '0;
                        pass_d  = 1'b0;
                        clr     = 1'b1;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        shreg_d = cfg_data;
                        wcnt_d  = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_d = shreg_q << 1;
                    wcnt_d  = wcnt_q + 1'b1;
                    bcnt_d  = bcnt_q + 1'b1;
                    // pass end wins over word end; leftover word bits are dropped
                    if (bcnt_q == BCW'(CHAIN_LEN - 1)) begin
                        bcnt_d = '0;
                        if (pass_q == LAST_PASS) begin
                            state_d = DONE;
                        end else begin
                            pass_d  = 1'b1;
                            state_d = FETCH;
                        end
                    end else if (wcnt_q == WCW'(WORD_W - 1)) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            pass_q   <= 1'b0;
            head_q   <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            pass_q   <= pass_d;
            head_q   <= (state_d == SHIFT) & shreg_d[WORD_W-1];
            clk_en_q <= (state_d == SHIFT);
        end
    end

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    logic verr_q;

    // pass 2 replays pass 1, so the tail must match the bit being driven
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            verr_q <= 1'b0;
        end else if (clr) begin
            verr_q <= 1'b0;
        end else if (state_q == SHIFT && pass_q && (ccff_tail != head_q)) begin
            verr_q <= 1'b1;
        end
    end

    assign verify_err = verr_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign verify_err  = 1'b0;
`endif

    assign ccff_head   = head_q;
    assign ccff_clk_en = clk_en_q;
    assign cfg_ready   = (state_q == FETCH);
    assign busy        = (state_q == FETCH) || (state_q == SHIFT);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: directed and random loads against a chain model.
// Works with or without CCFF_CHAIN_LOADER_VERIFY_EN.
module tb_ccff_chain_loader;
    localparam int L = 12;
    localparam int W = 8;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    logic         prog_clk   = 1'b0;
    logic         prog_rst_n = 1'b0;
    logic         start      = 1'b0;
    logic         abort      = 1'b0;
    logic         cfg_valid  = 1'b0;
    logic [W-1:0] cfg_data   = '0;
    logic         cfg_ready, ccff_head, ccff_clk_en, ccff_tail;
    logic         busy, done, verify_err;

    logic [L-1:0] chain = '0;
    logic         inj   = 1'b0;

    int total = 0;
    int bad   = 0;

    int   shift_cnt = 0;
    int   hs_cnt    = 0;
    int   busy_cyc  = 0;
    int   done_cnt  = 0;
    int   done_ok   = 0;
    logic prev_en   = 1'b0;
    logic bits [0:4095];

    logic [W-1:0] wq[$];

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .ccff_head  (ccff_head),
        .ccff_clk_en(ccff_clk_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err)
    );

    always #5 prog_clk = ~prog_clk;

    // ideal chain; inj flips the returning bit to model a corrupted flop
    assign ccff_tail = chain[L-1] ^ inj;
    always @(posedge prog_clk) begin
        if (ccff_clk_en) chain <= {chain[L-2:0], ccff_head};
    end

    always @(negedge prog_clk) begin
        if (ccff_clk_en) begin
            bits[shift_cnt % 4096] <= ccff_head;
            shift_cnt <= shift_cnt + 1;
        end
        if (cfg_valid && cfg_ready) hs_cnt <= hs_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (prev_en) done_ok <= done_ok + 1;
        end
        prev_en <= ccff_clk_en;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
    endtask

    task automatic run_load(input string tg, input int gap_at, input int gap_len,
                            input bit rnd, input bit flip);
        int n, idx, gap, cyc, k, b0, h0, c0, d0, k0;
        logic [2*L-1:0] ov, ev;
        n  = wq.size() * NP;
        b0 = shift_cnt; h0 = hs_cnt; c0 = busy_cyc;
        d0 = done_cnt;  k0 = done_ok;
        pulse_start();
        chk({tg, ".busy0"},  64'(busy), 64'(1));
        chk({tg, ".rdy0"},   64'(cfg_ready), 64'(1));
        chk({tg, ".vclr"},   64'(verify_err), 64'(0));
        idx = 0; gap = 0; cyc = 0;
        while (done_cnt == d0 && cyc < 1000) begin
            cfg_valid = 1'b0;
            cfg_data  = W'($urandom);
            if (cfg_ready && idx < n) begin
                if (idx == gap_at && gap < gap_len) begin
                    gap++;
                end else if (!(rnd && $urandom_range(0, 2) == 0)) begin
                    if (flip && idx == wq.size()) inj = 1'b1;
                    cfg_valid = 1'b1;
                    cfg_data  = wq[idx % wq.size()];
                    idx++;
                end
            end else if (!cfg_ready) begin
                cfg_valid = 1'($urandom_range(0, 1));
            end
            @(posedge prog_clk); #1;
            cyc++;
        end
        cfg_valid = 1'b0;
        inj = 1'b0;
        chk({tg, ".timeout"}, 64'(cyc >= 1000), 64'(0));
        ev = '0; ov = '0; k = 0;
        for (int p = 0; p < NP; p++)
            for (int w = 0; w < wq.size(); w++)
                for (int b = W - 1; b >= 0; b--)
                    if (k < L * (p + 1)) begin
                        ev[k] = wq[w][b];
                        k++;
                    end
        for (int i = 0; i < L * NP; i++) ov[i] = bits[(b0 + i) % 4096];
        chk({tg, ".bits"},   64'(ov), 64'(ev));
        chk({tg, ".shifts"}, 64'(shift_cnt - b0), 64'(L * NP));
        chk({tg, ".hs"},     64'(hs_cnt - h0), 64'(n));
        chk({tg, ".done"},   64'(done_cnt - d0), 64'(1));
        chk({tg, ".donepos"}, 64'(done_ok - k0), 64'(1));
        if (!rnd) chk({tg, ".cycles"}, 64'(busy_cyc - c0), 64'(L * NP + n + gap_len));
        chk({tg, ".idle"},   64'({busy, ccff_clk_en, cfg_ready, done}), 64'(0));
        chk({tg, ".verr"},   64'(verify_err), 64'(flip && NP == 2));
    endtask

    initial begin
        int d0, b0, cyc;
        repeat (2) @(posedge prog_clk);
        #1;
        chk("rst.ready", 64'(cfg_ready), 64'(0));
        chk("rst.head",  64'(ccff_head), 64'(0));
        chk("rst.clken", 64'(ccff_clk_en), 64'(0));
        chk("rst.busy",  64'(busy), 64'(0));
        chk("rst.done",  64'(done), 64'(0));
        chk("rst.verr",  64'(verify_err), 64'(0));
        #1 prog_rst_n = 1'b1;

        wq = {8'hF0, 8'h3C};
        run_load("seq", -1, 0, 1'b0, 1'b0);

        wq = {W'($urandom), W'($urandom)};
        run_load("gap", 1, 5, 1'b0, 1'b0);

        // abort part-way through the first word
        wq = {8'h96, 8'h3C};
        d0 = done_cnt;
        pulse_start();
        cfg_valid = 1'b1;
        cfg_data  = wq[0];
        b0 = shift_cnt; cyc = 0;
        while (shift_cnt - b0 < 3 && cyc < 50) begin
            @(posedge prog_clk); #1;
            cyc++;
        end
        chk("abort.reach", 64'(cyc >= 50), 64'(0));
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        cfg_valid = 1'b0;
        chk("abort.clken", 64'(ccff_clk_en), 64'(0));
        chk("abort.ready", 64'(cfg_ready), 64'(0));
        chk("abort.busy",  64'(busy), 64'(0));
        repeat (5) @(posedge prog_clk);
        #1 chk("abort.nodone", 64'(done_cnt - d0), 64'(0));
        run_load("post_abort", -1, 0, 1'b0, 1'b0);

        // asynchronous reset in the middle of a word
        pulse_start();
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        b0 = shift_cnt; cyc = 0;
        while (shift_cnt - b0 < 2 && cyc < 50) begin
            @(posedge prog_clk); #1;
            cyc++;
        end
        #2 prog_rst_n = 1'b0;
        #1;
        chk("arst.outs", 64'({cfg_ready, ccff_head, ccff_clk_en, busy, done, verify_err}), 64'(0));
        cfg_valid = 1'b0;
        @(posedge prog_clk); #2 prog_rst_n = 1'b1;
        wq = {8'hA5, 8'h0F};
        run_load("post_rst", -1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            wq = {W'($urandom), W'($urandom)};
            run_load($sformatf("rnd%0d", r), -1, 0, 1'b1, 1'b0);
        end

        wq = {8'h5A, 8'hA5};
        run_load("vfy_ok", -1, 0, 1'b0, 1'b0);
        run_load("vfy_bad", -1, 0, 1'b0, 1'b1);
        run_load("vfy_clr", -1, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
